// File: rtl/kronos_pkg.sv
// Shared kronos constants and the result-queue entry type.
package kronos_pkg;

    localparam int unsigned RQ_DEPTH  = 4;
    localparam int unsigned RQ_ID_W   = 4;
    localparam int unsigned RQ_RD_W   = 5;
    localparam int unsigned RQ_XLEN   = 32;
    localparam int unsigned RQ_NUM_RD = 2;
    localparam int unsigned RQ_DATA_W = RQ_NUM_RD * RQ_XLEN;

    // One in-flight instruction: status flags, destination and result payload.
    typedef struct packed {
        logic                 valid;
        logic                 has_data;
        logic                 committed;
        logic                 killed;
        logic [RQ_ID_W-1:0]   id;
        logic [RQ_RD_W-1:0]   rd;
        logic                 we;
        logic [RQ_DATA_W-1:0] data;
    } rq_entry_t;

endpackage

// File: rtl/kronos_result_queue.sv
// In-order result buffer between the execute datapath and the XIF result port.
// Entries are allocated at issue, filled in order by the datapath, marked by
// commit/kill, and retired from the head once both data and commit are present.
module kronos_result_queue
    import kronos_pkg::*;
#(
    parameter int unsigned DEPTH  = RQ_DEPTH,
    parameter int unsigned ID_W   = RQ_ID_W,
    parameter int unsigned RD_W   = RQ_RD_W,
    parameter int unsigned XLEN   = RQ_XLEN,
    parameter int unsigned NUM_RD = RQ_NUM_RD
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic                     alloc_valid_i,
    output logic                     alloc_ready_o,
    input  logic [ID_W-1:0]          alloc_id_i,
    input  logic [RD_W-1:0]          alloc_rd_i,
    input  logic                     alloc_we_i,
    input  logic                     exec_done_i,
    input  logic [NUM_RD*XLEN-1:0]   exec_data_i,
    input  logic                     commit_valid_i,
    input  logic [ID_W-1:0]          commit_id_i,
    input  logic                     commit_kill_i,
    output logic                     result_valid_o,
    input  logic                     result_ready_i,
    output logic [ID_W-1:0]          result_id_o,
    output logic [RD_W-1:0]          result_rd_o,
    output logic                     result_we_o,
    output logic [NUM_RD*XLEN-1:0]   result_data_o,
    output logic [$clog2(DEPTH):0]   count_o,
    output logic                     empty_o,
    output logic                     full_o,
    output logic                     err_o
);

    localparam int unsigned IW = $clog2(DEPTH);
    localparam int unsigned PW = IW + 1;

    rq_entry_t       q [DEPTH];
    logic [PW-1:0]   wr, ex, hd;
    logic            err;

    logic [IW-1:0]   wr_idx, ex_idx, hd_idx;
    rq_entry_t       head;
    logic            head_done, pop, alloc_fire, exec_fire;
    logic [DEPTH-1:0] match;
    logic            hit, alloc_commit;
    logic [IW-1:0]   hit_idx;

    // Returns {found, index} of the first set bit walking forward from start,
    // i.e. the oldest matching entry relative to the head.
    function automatic logic [IW:0] pick_oldest(input logic [DEPTH-1:0] m,
                                                input logic [IW-1:0]    start);
        logic [IW:0]   r;
        logic [IW-1:0] idx;
        r = '0;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            idx = start + IW'(i);
            if (m[idx]) r = {1'b1, idx};
        end
        return r;
    endfunction

    assign wr_idx = wr[IW-1:0];
    assign ex_idx = ex[IW-1:0];
    assign hd_idx = hd[IW-1:0];

    assign full_o        = (wr[IW] != hd[IW]) && (wr_idx == hd_idx);
    assign empty_o       = (wr == hd);
    assign alloc_ready_o = !full_o;
    assign count_o       = wr - hd;
    assign err_o         = err;

    assign alloc_fire = alloc_valid_i && !full_o;
    assign exec_fire  = exec_done_i && (ex != wr);

    // Head retirement: emit when live, drop silently when killed.
    always_comb begin
        head           = q[hd_idx];
        head_done      = head.valid && head.committed && head.has_data;
        result_valid_o = head_done && !head.killed;
        pop            = head_done && (head.killed || result_ready_i);
        result_id_o    = result_valid_o ? head.id   : '0;
        result_rd_o    = result_valid_o ? head.rd   : '0;
        result_we_o    = result_valid_o ? head.we   : 1'b0;
        result_data_o  = result_valid_o ? head.data : '0;
    end

    // Commit lookup: oldest uncommitted live entry wins; the entry being
    // allocated this cycle only catches the commit if nothing older matched.
    always_comb begin
        for (int i = 0; i < DEPTH; i++)
            match[i] = commit_valid_i && q[i].valid && !q[i].committed && (q[i].id == commit_id_i);
        {hit, hit_idx} = pick_oldest(match, hd_idx);
        alloc_commit   = commit_valid_i && !hit && (alloc_id_i == commit_id_i);
    end

    // Pointer and entry state. The alloc, exec, commit and pop targets are
    // always distinct entries, so the partial writes never collide.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr  <= '0;
            ex  <= '0;
            hd  <= '0;
            err <= 1'b0;
            for (int i = 0; i < DEPTH; i++) q[i] <= '0;
        end else begin
            if (alloc_fire) begin
                q[wr_idx] <= '{valid: 1'b1, has_data: 1'b0,
                               committed: alloc_commit,
                               killed: alloc_commit && commit_kill_i,
                               id: alloc_id_i, rd: alloc_rd_i, we: alloc_we_i,
                               data: '0};
                wr <= wr + 1'b1;
            end
            if (exec_fire) begin
                q[ex_idx].data     <= exec_data_i;
                q[ex_idx].has_data <= 1'b1;
                ex <= ex + 1'b1;
            end
            if (hit) begin
                q[hit_idx].committed <= 1'b1;
                q[hit_idx].killed    <= commit_kill_i;
            end
            if (pop) begin
                q[hd_idx].valid <= 1'b0;
                hd <= hd + 1'b1;
            end
            if (exec_done_i && !exec_fire) err <= 1'b1;
        end
    end

endmodule

// File: doc/kronos_result_queue.md
# kronos_result_queue

Parametrised in-flight tracker and result buffer between the kronos execute datapath and the XIF result interface. It holds destination register, instruction ID, commit/kill status and result data for up to DEPTH outstanding instructions, replacing the single rd/id hold register. Results are emitted in order, only after both execution and commit. Killed instructions are discarded silently.

## Interface
- DEPTH, 4: queue entries; power of two, ≥2.
- ID_W, 4: XIF instruction ID width.
- RD_W, 5: destination register index width.
- XLEN, 32: result word width.
- NUM_RD, 2: result words per instruction; data width is NUM_RD*XLEN.
- clk_i  in  1  clock.
- rst_ni  in  1  reset, asynchronous, active-low.
- alloc_valid_i  in  1  issue stage accepted an instruction.
- alloc_ready_o  out  1  entry available (= !full_o).
- alloc_id_i  in  ID_W  ID of allocated instruction.
- alloc_rd_i  in  RD_W  destination register.
- alloc_we_i  in  1  instruction writes rd.
- exec_done_i  in  1  datapath produced the next in-order result.
- exec_data_i  in  NUM_RD*XLEN  result payload.
- commit_valid_i  in  1  XIF commit handshake.
- commit_id_i  in  ID_W  committed/killed ID.
- commit_kill_i  in  1  instruction is killed.
- result_valid_o  out  1  head result available.
- result_ready_i  in  1  core accepts result.
- result_id_o  out  ID_W; result_rd_o  out  RD_W; result_we_o  out  1; result_data_o  out  NUM_RD*XLEN: head entry fields.
- count_o  out  $clog2(DEPTH)+1  occupied entries.
- empty_o, full_o  out  1  occupancy flags.
- err_o  out  1  sticky: exec_done_i with no entry awaiting data.

## Operation
- Three pointers, each $clog2(DEPTH)+1 bits and wrapping modulo 2*DEPTH: wr (allocate), ex (next entry awaiting data), hd (head). full = MSBs differ and lower bits equal; empty = wr==hd.
- Each entry holds valid, has_data, committed, killed, id, rd, we, data.
- Alloc: alloc_valid_i && alloc_ready_o writes entry[wr] with has_data=committed=killed=0, then wr++. alloc_ready_o depends only on registered state; a pop in the same cycle does not free a slot for the same cycle's alloc.
- Exec: exec_done_i while ex!=wr stores data into entry[ex], sets has_data, ex++. exec_done_i while ex==wr is ignored and sets err_o. Data written in the alloc cycle is not eligible.
- Commit: match commit_id_i against valid entries with committed==0. On multiple matches, the oldest from hd wins. A commit in the same cycle as an alloc carrying the same ID applies to the new entry only when no older entry matches. On a match, set committed and set killed=commit_kill_i. With no match, the commit is ignored.
- Head: committed && !killed && has_data → result_valid_o=1. On handshake, the entry is freed and hd++. If committed && killed && has_data, the entry is freed and hd++ with result_valid_o=0. If killed but data not yet arrived, the entry waits for exec_done (keeps the datapath and ex pointer aligned).
- Result fields are driven from entry[hd] and are 0 when result_valid_o=0.

## Timing
- Reset: all entries invalid; pointers 0; result_valid_o=0; result fields 0; count_o=0; empty_o=1; full_o=0; alloc_ready_o=1; err_o=0. Reset mid-operation drops all entries with no result emitted.
- Latency: the later of exec_done_i and commit at cycle N gives result_valid_o=1 at N+1 (head entry).
- Result outputs hold stable while result_valid_o && !result_ready_i.
- Killed-head discard takes 1 cycle; back-to-back results sustain 1 per cycle.
- Alloc, exec, commit and pop may all occur in one cycle; count_o = count + alloc − pop.
- Full: alloc_valid_i while full is a protocol violation; it is not accepted and no state changes.

## Structure
- kronos_pkg gains: rq_entry_t (packed entry struct, widths from package constants) and default DEPTH/NUM_RD localparams.
- Single module. The ID-match priority search is an inline function; no sub-module is needed.

## Test plan
- Alloc id=3 rd=7 we=1, exec data=0xDEAD_BEEF_0000_0001, commit id=3 → result_valid_o next cycle, id=3, rd=7, data matches; count_o returns to 0.
- Commit before exec: alloc ids 1,2; commit 2 then 1; exec twice → results id=1 then id=2, in order, on consecutive cycles.
- Kill: alloc ids 4,5; commit 4 kill=1, commit 5; exec ×2 → only id=5 emitted; id=4 never visible.
- Fill DEPTH=4 → full_o=1, alloc_ready_o=0; pop with result_ready_i=1 while alloc_valid_i=1 → alloc refused that cycle, accepted the next.
- Backpressure: result_ready_i=0 for 5 cycles → outputs stable; exec_done_i on an empty queue → err_o=1 and stays set.
- Assert rst_ni mid-stream with 3 entries → all outputs at reset values; no result after release.
